buzzer_sequencer: RTL and testbench
===================================

BUZZER_SEQUENCER -- requirements
Module: buzzer_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 1000, meaning timing tick rate in Hz (1 ms tick).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to play the selected pattern; sampled only in IDLE.
REQ-006 The block SHALL have port pattern_sel, input, 2 bits: pattern index; latched on an accepted start.
REQ-007 The block SHALL have port stop, input, 1 bit: abort the current pattern.
REQ-008 The block SHALL have port buzzer_on, output, 1 bit: registered enable that drives the downstream tone generator's buzzer_on input.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse on natural pattern completion.

Function
REQ-011 Pattern table, in ticks (on/off/beeps), SHALL be:
- 0 = 200/0/1
- 1 = 100/100/3
- 2 = 500/500/infinite, repeating until stop
- 3 = 1000/0/1
REQ-012 The state machine SHALL use states IDLE, ON, OFF, and no others.
REQ-013 In IDLE, a start high with stop low SHALL latch pattern_sel, load beep count, clear the prescaler and tick counter, and enter ON on the next edge.
REQ-014 buzzer_on SHALL be 1 exactly while the state is ON, so it rises one cycle after the accepted start.
REQ-015 The prescaler SHALL count 0 to CLK_HZ/TICK_HZ-1 and emit a one-cycle tick at terminal count, restarting from 0 on every accepted start and every phase change.
REQ-016 Each ON or OFF phase SHALL last exactly (phase_ticks × CLK_HZ/TICK_HZ) clock cycles.
REQ-017 At the end of an ON phase, if the beeps remaining after this one are 0, the block SHALL go to IDLE and pulse done in the same cycle buzzer_on falls; no trailing OFF phase is played.
REQ-018 Otherwise, at the end of an ON phase, the block SHALL decrement the beep counter and enter OFF.
REQ-019 At the end of an OFF phase, the block SHALL enter ON.
REQ-020 Pattern 2 SHALL never decrement its beep counter and SHALL never assert done.
REQ-021 start asserted while busy SHALL be ignored, with no relatch of pattern_sel.
REQ-022 stop high in ON or OFF SHALL force IDLE on the next edge: buzzer_on and busy go 0 that edge, and done is not pulsed.
REQ-023 start and stop both high in IDLE SHALL be resolved in favour of stop: the block stays in IDLE.
REQ-024 Changes on pattern_sel while busy SHALL have no effect.
REQ-025 The tick counter SHALL be at least 10 bits wide (max 1000), and the beep counter SHALL be 2 bits wide.

Reset
REQ-026 On rst_n low, asynchronously, the block SHALL set state to IDLE, all counters to 0, latched pattern to 0, and buzzer_on, busy and done to 0.
REQ-027 Reset asserted mid-pattern SHALL drop buzzer_on within the same reset assertion, with no done pulse.
REQ-028 After reset release, the first accepted start SHALL behave identically to one accepted after power-up.

Structure
REQ-029 Shared package buzzer_pkg SHALL hold:
- the state enum (IDLE/ON/OFF)
- the 2-bit pattern index type
- the pattern table constants (on ticks, off ticks, beep count, repeat flag)
REQ-030 The prescaler SHALL be implemented as a separate sub-module, tick_gen, with a synchronous clear input and a tick output.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
Bench parameters are CLK_HZ=10_000 and TICK_HZ=1000, giving 10 cycles per tick.
REQ-032 Pattern 0: start pulse at cycle 0 -> buzzer_on high for cycles 1-2000, done pulse at cycle 2001, busy low from cycle 2001.
REQ-033 Pattern 1: single start -> three 1000-cycle high windows separated by 1000-cycle low windows; done coincides with the third falling edge; total busy time 5000 cycles.
REQ-034 Pattern 2: start, then stop at cycle 7500 -> alternating 5000-cycle on/off windows, buzzer_on low and busy low at cycle 7501, no done pulse ever.
REQ-035 Start and pattern_sel changes while busy -> timing and pattern unaffected; start and stop together in IDLE -> no activity.
REQ-036 rst_n asserted during an ON phase of pattern 3 -> buzzer_on, busy and done go 0 immediately; after release, a new start of pattern 0 gives exactly 2000 cycles high.

Source files
------------

// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
// Shared types and the pattern table for the buzzer sequencer.
//   state_e    : sequencer states (IDLE / ON / OFF)
//   pattern_t  : 2-bit pattern index
//   pat_*()    : pattern table lookups (on ticks, off ticks, beeps, repeat)
// -----------------------------------------------------------------------------
package buzzer_pkg;

    localparam int TICK_W = 10;  // phase lengths up to 1000 ticks
    localparam int BEEP_W = 2;   // beep counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    typedef logic [1:0] pattern_t;

    // Length of the ON phase, in ticks.
    function automatic logic [TICK_W-1:0] pat_on_ticks(input pattern_t p);
        logic [TICK_W-1:0] r;
        case (p)
            2'd0:    r = 10'd200;
            2'd1:    r = 10'd100;
            2'd2:    r = 10'd500;
            2'd3:    r = 10'd1000;
            default: r = 10'd200;
        endcase
        return r;
    endfunction

    // Length of the OFF phase, in ticks.
    function automatic logic [TICK_W-1:0] pat_off_ticks(input pattern_t p);
        logic [TICK_W-1:0] r;
        case (p)
            2'd0:    r = 10'd0;
            2'd1:    r = 10'd100;
            2'd2:    r = 10'd500;
            2'd3:    r = 10'd0;
            default: r = 10'd0;
        endcase
        return r;
    endfunction

    // Number of beeps for finite patterns.
    function automatic logic [BEEP_W-1:0] pat_beeps(input pattern_t p);
        logic [BEEP_W-1:0] r;
        case (p)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd3;
            2'd2:    r = 2'd0;
            2'd3:    r = 2'd1;
            default: r = 2'd1;
        endcase
        return r;
    endfunction

    // Pattern repeats until stopped.
    function automatic logic pat_repeat(input pattern_t p);
        logic r;
        case (p)
            2'd2:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler: counts 0..DIV-1 and raises tick for one cycle at terminal count.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, restarts the count from 0
//   tick  : one-cycle pulse when the count is DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Prescaler count register, wraps at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == TERM) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = (cnt_r == TERM);

endmodule

// File: rtl/buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// buzzer_sequencer
// Plays one of four beep patterns by sequencing a registered buzzer enable.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : play request, only honoured in IDLE (stop has priority)
//   pattern_sel : pattern index, latched on an accepted start
//   stop        : abort the current pattern, no done pulse
//   buzzer_on   : registered enable, high exactly while in ON
//   busy        : high whenever not IDLE
//   done        : one-cycle pulse on natural completion
// -----------------------------------------------------------------------------
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] pattern_sel,
    input  logic       stop,
    output logic       buzzer_on,
    output logic       busy,
    output logic       done
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_e              state_r, state_next_s;
    pattern_t            pat_r, pat_next_s;
    logic [TICK_W-1:0]   tick_cnt_r, tick_cnt_next_s;
    logic [BEEP_W-1:0]   beep_cnt_r, beep_cnt_next_s;
    logic [TICK_W-1:0]   phase_ticks_s;
    logic                phase_end_s;
    logic                presc_clr_s;
    logic                tick_s;
    logic                done_next_s;
    logic                buzzer_on_r, busy_r, done_r;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr_s),
        .tick  (tick_s)
    );

    // Next-state, counter updates and prescaler clear.
    always_comb begin
        state_next_s    = state_r;
        pat_next_s      = pat_r;
        tick_cnt_next_s = tick_cnt_r;
        beep_cnt_next_s = beep_cnt_r;
        presc_clr_s     = 1'b0;
        done_next_s     = 1'b0;

        if (state_r == OFF) begin
            phase_ticks_s = pat_off_ticks(pat_r);
        end else begin
            phase_ticks_s = pat_on_ticks(pat_r);
        end
        // The final tick of a phase arrives while the counter holds ticks-1.
        phase_end_s = tick_s && (tick_cnt_r == (phase_ticks_s - 10'd1));

        case (state_r)
            IDLE: begin
                if (start && !stop) begin
                    state_next_s    = ON;
                    pat_next_s      = pattern_sel;
                    beep_cnt_next_s = pat_beeps(pattern_sel);
                    tick_cnt_next_s = '0;
                    presc_clr_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ON: begin
                if (stop) begin
                    state_next_s    = IDLE;
                    tick_cnt_next_s = '0;
                    beep_cnt_next_s = '0;
                    presc_clr_s     = 1'b1;
                end else if (phase_end_s) begin
                    tick_cnt_next_s = '0;
                    presc_clr_s     = 1'b1;
                    if (pat_repeat(pat_r)) begin
                        state_next_s = OFF;
                    end else if (beep_cnt_r == 2'd1) begin
                        // Last beep: finish without a trailing OFF phase.
                        state_next_s    = IDLE;
                        beep_cnt_next_s = '0;
                        done_next_s     = 1'b1;
                    end else begin
                        state_next_s    = OFF;
                        beep_cnt_next_s = beep_cnt_r - 2'd1;
                    end
                end else if (tick_s) begin
                    tick_cnt_next_s = tick_cnt_r + 10'd1;
                end else begin
                    tick_cnt_next_s = tick_cnt_r;
                end
            end
            OFF: begin
                if (stop) begin
                    state_next_s    = IDLE;
                    tick_cnt_next_s = '0;
                    beep_cnt_next_s = '0;
                    presc_clr_s     = 1'b1;
                end else if (phase_end_s) begin
                    state_next_s    = ON;
                    tick_cnt_next_s = '0;
                    presc_clr_s     = 1'b1;
                end else if (tick_s) begin
                    tick_cnt_next_s = tick_cnt_r + 10'd1;
                end else begin
                    tick_cnt_next_s = tick_cnt_r;
                end
            end
            default: begin
                state_next_s    = IDLE;
                tick_cnt_next_s = '0;
                beep_cnt_next_s = '0;
                presc_clr_s     = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pat_r       <= '0;
            tick_cnt_r  <= '0;
            beep_cnt_r  <= '0;
            buzzer_on_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pat_r       <= pat_next_s;
            tick_cnt_r  <= tick_cnt_next_s;
            beep_cnt_r  <= beep_cnt_next_s;
            buzzer_on_r <= (state_next_s == ON);
            busy_r      <= (state_next_s != IDLE);
            done_r      <= done_next_s;
        end
    end

    assign buzzer_on = buzzer_on_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_buzzer_sequencer
// Directed bench for buzzer_sequencer at 10 clock cycles per tick.
// Edge 0 is the edge that accepts start; checks are taken 1 ns after an edge.
// -----------------------------------------------------------------------------
module tb_buzzer_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] pattern_sel;
    logic       stop;
    logic       buzzer_on;
    logic       busy;
    logic       done;

    int errors;
    int checks;
    int cyc;
    int done_pulses;

    buzzer_sequencer #(.CLK_HZ(10_000), .TICK_HZ(1000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pattern_sel (pattern_sel),
        .stop        (stop),
        .buzzer_on   (buzzer_on),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses seen on rising edges.
    always @(posedge clk) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
        end
    endtask

    task automatic to_edge(input int n);
        step(n - cyc);
    endtask

    // Present start for one edge; afterwards cyc==0 is the accept edge.
    task automatic go(input logic [1:0] p);
        start       = 1'b1;
        pattern_sel = p;
        step(1);
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic on_e, input logic busy_e, input logic done_e);
        chk({tag, ".buzzer_on"}, buzzer_on, on_e);
        chk({tag, ".busy"}, busy, busy_e);
        chk({tag, ".done"}, done, done_e);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs == exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        done_pulses = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        pattern_sel = 2'd0;

        // Reset state
        step(3);
        chk3("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(2);
        chk3("idle", 1'b0, 1'b0, 1'b0);

        // Pattern 0: 2000 cycles on, done as buzzer falls
        go(2'd0);
        chk3("p0.rise", 1'b1, 1'b1, 1'b0);
        to_edge(1999);
        chk3("p0.last_on", 1'b1, 1'b1, 1'b0);
        to_edge(2000);
        chk3("p0.end", 1'b0, 1'b0, 1'b1);
        to_edge(2001);
        chk3("p0.after", 1'b0, 1'b0, 1'b0);
        step(5);

        // Pattern 1 with start/pattern_sel disturbance while busy
        go(2'd1);
        chk3("p1.on1", 1'b1, 1'b1, 1'b0);
        to_edge(999);
        chk3("p1.on1_end", 1'b1, 1'b1, 1'b0);
        to_edge(1000);
        chk3("p1.off1", 1'b0, 1'b1, 1'b0);
        to_edge(1500);
        start       = 1'b1;
        pattern_sel = 2'd3;
        step(1);
        start = 1'b0;
        to_edge(1999);
        chk3("p1.off1_end", 1'b0, 1'b1, 1'b0);
        to_edge(2000);
        chk3("p1.on2", 1'b1, 1'b1, 1'b0);
        to_edge(3000);
        chk3("p1.off2", 1'b0, 1'b1, 1'b0);
        to_edge(4000);
        chk3("p1.on3", 1'b1, 1'b1, 1'b0);
        to_edge(4999);
        chk3("p1.on3_end", 1'b1, 1'b1, 1'b0);
        to_edge(5000);
        chk3("p1.end", 1'b0, 1'b0, 1'b1);
        to_edge(5001);
        chk3("p1.after", 1'b0, 1'b0, 1'b0);
        step(5);

        // Pattern 2 repeats until stopped, never done
        done_pulses = 0;
        go(2'd2);
        chk3("p2.on1", 1'b1, 1'b1, 1'b0);
        to_edge(4999);
        chk3("p2.on1_end", 1'b1, 1'b1, 1'b0);
        to_edge(5000);
        chk3("p2.off1", 1'b0, 1'b1, 1'b0);
        to_edge(7499);
        chk3("p2.pre_stop", 1'b0, 1'b1, 1'b0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk3("p2.stopped", 1'b0, 1'b0, 1'b0);
        step(20);
        chk_int("p2.done_pulses", done_pulses, 0);

        // Stop during an ON phase of pattern 2
        go(2'd2);
        to_edge(300);
        chk3("p2b.on", 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk3("p2b.stopped", 1'b0, 1'b0, 1'b0);
        step(3);

        // Start and stop together in IDLE: nothing happens
        start       = 1'b1;
        stop        = 1'b1;
        pattern_sel = 2'd0;
        step(1);
        chk3("both.1", 1'b0, 1'b0, 1'b0);
        step(3);
        start = 1'b0;
        stop  = 1'b0;
        step(1);
        chk3("both.2", 1'b0, 1'b0, 1'b0);

        // Reset mid-ON of pattern 3, then a clean pattern 0
        done_pulses = 0;
        go(2'd3);
        to_edge(500);
        chk3("p3.on", 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk3("p3.reset", 1'b0, 1'b0, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(2);
        chk3("p3.idle", 1'b0, 1'b0, 1'b0);
        chk_int("p3.done_pulses", done_pulses, 0);
        go(2'd0);
        chk3("rp0.rise", 1'b1, 1'b1, 1'b0);
        to_edge(1999);
        chk3("rp0.last_on", 1'b1, 1'b1, 1'b0);
        to_edge(2000);
        chk3("rp0.end", 1'b0, 1'b0, 1'b1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
